// File: rtl/router_fifo_pkt.sv
// Packet-aware output FIFO for one router channel: header-tagged storage, read-side packet
// tracking, soft flush, idle-read timeout flush and occupancy count.
module router_fifo_pkt #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     read_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_done,
  output logic                     timeout_flush
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Idle counter only needs to reach TIMEOUT-1
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, w_wr_ptr_d;
  logic [AW-1:0]     r_rd_ptr, w_rd_ptr_d;
  logic [AW:0]       r_count, w_count_d;
  logic [DATA_W-2:0] r_rem, w_rem_d;
  logic [TW-1:0]     r_to_cnt, w_to_cnt_d;
  logic [DATA_W-1:0] r_data_out, w_data_out_d;
  logic              r_pkt_done, w_pkt_done_d;
  logic              r_timeout_flush;

  logic              w_empty, w_full;
  logic              w_wr_acc, w_rd_acc, w_idle;
  logic              w_auto_flush, w_flush;
  logic [DATA_W:0]   w_rd_word;
  logic              w_rd_hdr;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_wr_acc     = write_enb && !w_full;
  assign w_rd_acc     = read_enb && !w_empty;
  assign w_idle       = !w_empty && !read_enb;
  assign w_auto_flush = (TIMEOUT != 0) && w_idle && (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_flush      = soft_reset || w_auto_flush;
  assign w_rd_word    = r_mem[r_rd_ptr];
  assign w_rd_hdr     = w_rd_word[DATA_W];

  always_comb begin
    w_wr_ptr_d   = r_wr_ptr;
    w_rd_ptr_d   = r_rd_ptr;
    w_count_d    = r_count;
    w_rem_d      = r_rem;
    w_to_cnt_d   = r_to_cnt;
    w_data_out_d = r_data_out;
    w_pkt_done_d = 1'b0;
    if (w_flush) begin
      w_wr_ptr_d   = '0;
      w_rd_ptr_d   = '0;
      w_count_d    = '0;
      w_rem_d      = '0;
      w_to_cnt_d   = '0;
      w_data_out_d = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_d = r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        w_rd_ptr_d   = r_rd_ptr + 1'b1;
        w_data_out_d = w_rd_word[DATA_W-1:0];
        if (w_rd_hdr) begin
          // Header length field counts payload; +1 covers the trailing parity word
          w_rem_d = {1'b0, w_rd_word[DATA_W-1:2]} + 1'b1;
        end else if (r_rem != '0) begin
          w_rem_d      = r_rem - 1'b1;
          w_pkt_done_d = (r_rem == (DATA_W-1)'(1));
        end
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_d = r_count + 1'b1;
        2'b01:   w_count_d = r_count - 1'b1;
        default: w_count_d = r_count;
      endcase
      if (w_rd_acc || w_empty) w_to_cnt_d = '0;
      else if (w_idle)         w_to_cnt_d = r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_rem           <= '0;
      r_to_cnt        <= '0;
      r_data_out      <= '0;
      r_pkt_done      <= 1'b0;
      r_timeout_flush <= 1'b0;
    end else begin
      r_wr_ptr        <= w_wr_ptr_d;
      r_rd_ptr        <= w_rd_ptr_d;
      r_count         <= w_count_d;
      r_rem           <= w_rem_d;
      r_to_cnt        <= w_to_cnt_d;
      r_data_out      <= w_data_out_d;
      r_pkt_done      <= w_pkt_done_d;
      r_timeout_flush <= w_auto_flush;
    end
  end

  // Storage is not reset or flushed; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_flush) r_mem[r_wr_ptr] <= {lfd_state, data_in};
  end

  assign data_out      = r_data_out;
  assign empty         = w_empty;
  assign full          = w_full;
  assign count         = r_count;
  assign pkt_done      = r_pkt_done;
  assign timeout_flush = r_timeout_flush;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed bench for router_fifo_pkt at default parameters (8-bit data, 16 deep, timeout 30).
module tb_router_fifo_pkt;

  logic       clk = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       empty, full, pkt_done, timeout_flush;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse;

  router_fifo_pkt dut (
    .clk           (clk),
    .resetn        (resetn),
    .soft_reset    (soft_reset),
    .write_enb     (write_enb),
    .read_enb      (read_enb),
    .lfd_state     (lfd_state),
    .data_in       (data_in),
    .data_out      (data_out),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .pkt_done      (pkt_done),
    .timeout_flush (timeout_flush)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, then return 1 time unit after the capturing edge
  task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] d);
    write_enb = we;
    read_enb  = re;
    lfd_state = lfd;
    data_in   = d;
    @(posedge clk);
    #1;
    write_enb = 1'b0;
    read_enb  = 1'b0;
    lfd_state = 1'b0;
    data_in   = 8'h00;
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    #12;
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_pkt_done", pkt_done, 0);
    check_eq("rst_timeout_flush", timeout_flush, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of traffic
    cyc(1, 0, 0, 8'h33);
    check_eq("wr_empty_deassert", empty, 0);
    cyc(1, 0, 0, 8'h44);
    cyc(0, 1, 0, 8'h00);
    check_eq("pre_rst_data", data_out, 8'h33);
    check_eq("pre_rst_count", count, 1);
    write_enb = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check_eq("async_rst_count", count, 0);
    check_eq("async_rst_empty", empty, 1);
    check_eq("async_rst_data", data_out, 0);
    write_enb = 1'b0;
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_empty", empty, 1);

    // Fill past full; writes 17..20 must be dropped
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 0, 0, 8'(i));
      if (i == 16) check_eq("full_at_16", full, 1);
    end
    check_eq("fill_count", count, 16);
    check_eq("fill_full", full, 1);

    // Read+write while full: write dropped, count 15
    cyc(1, 1, 0, 8'hEE);
    check_eq("full_rw_data", data_out, 8'h01);
    check_eq("full_rw_count", count, 15);
    check_eq("full_rw_notfull", full, 0);
    for (int i = 2; i <= 16; i++) begin
      cyc(0, 1, 0, 8'h00);
      check_eq($sformatf("drain_%0d", i), data_out, 32'(i));
    end
    check_eq("drain_empty", empty, 1);
    check_eq("drain_count", count, 0);
    cyc(0, 1, 0, 8'h00);
    check_eq("read_empty_hold", data_out, 8'h10);
    check_eq("read_empty_count", count, 0);

    // Simultaneous read/write at count 5 keeps count and order
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h21 + i));
    check_eq("five_count", count, 5);
    cyc(1, 1, 0, 8'h26);
    check_eq("rw5_data", data_out, 8'h21);
    check_eq("rw5_count", count, 5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 8'h00);
      check_eq($sformatf("rw5_order_%0d", i), data_out, 32'(8'h22 + i));
    end
    check_eq("rw5_empty", empty, 1);

    // Packet: header 0x0C => 3 payload + parity; pkt_done with the parity word only
    cyc(1, 0, 1, 8'h0C);
    cyc(1, 0, 0, 8'hA1);
    cyc(1, 0, 0, 8'hA2);
    cyc(1, 0, 0, 8'hA3);
    cyc(1, 0, 0, 8'h5E);
    n_pulse = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 8'h00);
      if (pkt_done) n_pulse++;
      if (i == 4) begin
        check_eq("pkt_parity_data", data_out, 8'h5E);
        check_eq("pkt_done_on_parity", pkt_done, 1);
      end
    end
    cyc(0, 0, 0, 8'h00);
    check_eq("pkt_done_one_cycle", pkt_done, 0);
    check_eq("pkt_done_pulses", n_pulse, 1);

    // Stray non-header word outside a packet
    cyc(1, 0, 0, 8'h77);
    cyc(0, 1, 0, 8'h00);
    check_eq("stray_data", data_out, 8'h77);
    check_eq("stray_no_done", pkt_done, 0);

    // Timeout: writes 2 and 3 are already idle cycles, so 28 more reach 30
    cyc(1, 0, 0, 8'h51);
    cyc(1, 0, 0, 8'h52);
    cyc(1, 0, 0, 8'h53);
    for (int i = 0; i < 27; i++) cyc(0, 0, 0, 8'h00);
    check_eq("to_before_flush", timeout_flush, 0);
    check_eq("to_before_count", count, 3);
    cyc(0, 0, 0, 8'h00);
    check_eq("to_flush_pulse", timeout_flush, 1);
    check_eq("to_flush_count", count, 0);
    check_eq("to_flush_empty", empty, 1);
    check_eq("to_flush_data", data_out, 0);
    cyc(0, 0, 0, 8'h00);
    check_eq("to_flush_one_cycle", timeout_flush, 0);

    // Read on idle cycle 29 restarts the idle count
    cyc(1, 0, 0, 8'h61);
    cyc(1, 0, 0, 8'h62);
    cyc(1, 0, 0, 8'h63);
    for (int i = 0; i < 26; i++) cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    check_eq("to_read29_data", data_out, 8'h61);
    check_eq("to_read29_noflush", timeout_flush, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00);
    check_eq("to_read29_still_noflush", timeout_flush, 0);
    check_eq("to_read29_count", count, 2);

    // Soft reset beats a same-cycle write
    soft_reset = 1'b1;
    cyc(1, 0, 0, 8'h99);
    soft_reset = 1'b0;
    check_eq("soft_empty", empty, 1);
    check_eq("soft_count", count, 0);
    check_eq("soft_data", data_out, 0);
    cyc(0, 0, 0, 8'h00);
    check_eq("soft_write_dropped", empty, 1);
    cyc(1, 0, 0, 8'hC3);
    cyc(0, 1, 0, 8'h00);
    check_eq("soft_restart_data", data_out, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
